// File: rtl/lattice_energy_pkg.sv
// Shared constants, boundary-mode type and width helpers for the lattice energy pipeline.
package lattice_energy_pkg;

  localparam int unsigned DEF_NUM_TYPES      = 3;
  localparam int unsigned DEF_DATA_WIDTH     = 4;
  localparam int unsigned DEF_LATTICE_LENGTH = 11;
  localparam int unsigned DEF_TAG_WIDTH      = 6;
  localparam int unsigned DEF_POP_SIZE       = 50;
  localparam int unsigned DEF_ENERGY_WIDTH   = 10;

  typedef enum logic {
    BND_OPEN     = 1'b0,
    BND_PERIODIC = 1'b1
  } boundary_e;

  // Minimum output width that holds the worst-case energy without wrap.
  function automatic int unsigned energy_width(input int unsigned lattice_length,
                                               input int unsigned data_width);
    return $clog2(3 * lattice_length * ((1 << data_width) - 1) + 1);
  endfunction

  // Number of neighbour pairs summed: the wrap pair (L-1,0) exists only when periodic.
  function automatic int unsigned pair_count(input int unsigned lattice_length,
                                             input boundary_e   mode);
    return (mode == BND_PERIODIC) ? lattice_length : lattice_length - 1;
  endfunction

endpackage

// File: rtl/lattice_energy_pipe_if.sv
// Individual-in / result-out handshake bundle of the lattice energy pipeline.
interface lattice_energy_pipe_if #(
  parameter int unsigned DATA_WIDTH     = 4,
  parameter int unsigned LATTICE_LENGTH = 11,
  parameter int unsigned TAG_WIDTH      = 6,
  parameter int unsigned ENERGY_WIDTH   = 10
);
  logic                                 in_valid_i;
  logic                                 in_ready_o;
  logic [LATTICE_LENGTH*DATA_WIDTH-1:0] ind_vec_i;
  logic [TAG_WIDTH-1:0]                 ind_tag_i;
  logic                                 out_valid_o;
  logic                                 out_ready_i;
  logic [ENERGY_WIDTH-1:0]              energy_o;
  logic [TAG_WIDTH-1:0]                 tag_o;
  logic                                 last_o;
  logic                                 type_err_o;

  modport slave (
    input  in_valid_i, ind_vec_i, ind_tag_i, out_ready_i,
    output in_ready_o, out_valid_o, energy_o, tag_o, last_o, type_err_o
  );

  modport master (
    output in_valid_i, ind_vec_i, ind_tag_i, out_ready_i,
    input  in_ready_o, out_valid_o, energy_o, tag_o, last_o, type_err_o
  );
endinterface

// File: rtl/lattice_energy_adder_tree.sv
// Combinational sum of N packed unsigned terms, each zero-extended to OUT_W.
module lattice_energy_adder_tree #(
  parameter int unsigned N     = 2,
  parameter int unsigned IN_W  = 4,
  parameter int unsigned OUT_W = 10
) (
  input  logic [N*IN_W-1:0] terms_i,
  output logic [OUT_W-1:0]  sum_o
);

  // Accumulate every term at full output width.
  always_comb begin
    sum_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      sum_o = sum_o + OUT_W'(terms_i[i*IN_W +: IN_W]);
    end
  end

endmodule

// File: rtl/lattice_energy_pipe.sv
// Three-stage lattice energy evaluator: table lookup, partial sums, final sum.
module lattice_energy_pipe
  import lattice_energy_pkg::*;
#(
  parameter int unsigned NUM_TYPES      = DEF_NUM_TYPES,
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned LATTICE_LENGTH = DEF_LATTICE_LENGTH,
  parameter int unsigned TAG_WIDTH      = DEF_TAG_WIDTH,
  parameter int unsigned POP_SIZE       = DEF_POP_SIZE,
  parameter int unsigned ENERGY_WIDTH   = DEF_ENERGY_WIDTH
) (
  input  logic                                     clk_i,
  input  logic                                     rst_n,
  input  logic                                     cfg_we_i,
  input  logic [NUM_TYPES*DATA_WIDTH-1:0]           self_energy_i,
  input  logic [NUM_TYPES*NUM_TYPES*DATA_WIDTH-1:0] interact_i,
  input  logic                                     periodic_i,
  input  logic                                     pop_clr_i,
  lattice_energy_pipe_if.slave                     bus,
  output logic                                     idle_o,
  output logic                                     cfg_err_o
);

  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned NT = NUM_TYPES;
  localparam int unsigned L  = LATTICE_LENGTH;
  localparam int unsigned EW = ENERGY_WIDTH;
  localparam int unsigned TW = TAG_WIDTH;
  localparam int unsigned CW = (POP_SIZE > 1) ? $clog2(POP_SIZE) : 1;

  logic [DW-1:0] se_q [NT];
  logic [DW-1:0] se_d [NT];
  logic [DW-1:0] ie_q [NT*NT];
  logic [DW-1:0] ie_d [NT*NT];
  boundary_e     mode_q, mode_d;
  logic          cfg_err_q, cfg_err_d, cfg_accept;

  logic [L-1:0]          lk_ok;
  logic [L*DW-1:0]       lk_se;
  logic [L*(DW+1)-1:0]   lk_ie;

  logic                  s1_valid_q, s1_valid_d, s1_err_q, s1_err_d;
  logic [L*DW-1:0]       s1_se_q, s1_se_d;
  logic [L*(DW+1)-1:0]   s1_ie_q, s1_ie_d;
  logic [TW-1:0]         s1_tag_q, s1_tag_d;
  logic                  s2_valid_q, s2_valid_d, s2_err_q, s2_err_d;
  logic [EW-1:0]         s2_se_q, s2_se_d, s2_ie_q, s2_ie_d;
  logic [TW-1:0]         s2_tag_q, s2_tag_d;
  logic                  out_valid_q, out_valid_d, err_q, err_d;
  logic [EW-1:0]         energy_q, energy_d;
  logic [TW-1:0]         tag_q, tag_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic [EW-1:0]         se_sum, ie_sum, total;
  logic                  advance;

  assign advance        = ~(out_valid_q & ~bus.out_ready_i);
  assign bus.in_ready_o = advance;
  assign idle_o         = ~(s1_valid_q | s2_valid_q | out_valid_q);
  assign cfg_accept     = cfg_we_i & idle_o & ~bus.in_valid_i;
  assign cfg_err_o      = cfg_err_q;

  assign bus.out_valid_o = out_valid_q;
  assign bus.energy_o    = energy_q;
  assign bus.tag_o       = tag_q;
  assign bus.type_err_o  = err_q;
  assign bus.last_o      = out_valid_q & (cnt_q == CW'(POP_SIZE - 1));

  // Table/mode load, only while the pipeline is empty and no individual is offered.
  always_comb begin
    se_d      = se_q;
    ie_d      = ie_q;
    mode_d    = mode_q;
    cfg_err_d = cfg_we_i & ~cfg_accept;
    if (cfg_accept) begin
      for (int unsigned t = 0; t < NT; t++) se_d[t] = self_energy_i[t*DW +: DW];
      for (int unsigned k = 0; k < NT*NT; k++) ie_d[k] = interact_i[k*DW +: DW];
      mode_d = periodic_i ? BND_PERIODIC : BND_OPEN;
    end
  end

  // Per-site SE and per-pair doubled IE lookup; out-of-range codes match no type and read 0.
  always_comb begin
    logic [DW-1:0] ie_v;
    int unsigned   nb;
    lk_ok = '0;
    lk_se = '0;
    lk_ie = '0;
    for (int unsigned i = 0; i < L; i++) begin
      for (int unsigned t = 0; t < NT; t++) begin
        if (bus.ind_vec_i[i*DW +: DW] == DW'(t)) begin
          lk_ok[i]          = 1'b1;
          lk_se[i*DW +: DW] = se_q[t];
        end
      end
    end
    for (int unsigned p = 0; p < L; p++) begin
      nb   = (p == L - 1) ? 0 : p + 1;
      ie_v = '0;
      if (p < pair_count(L, mode_q)) begin
        for (int unsigned ta = 0; ta < NT; ta++) begin
          for (int unsigned tb = 0; tb < NT; tb++) begin
            if (bus.ind_vec_i[p*DW +: DW] == DW'(ta) && bus.ind_vec_i[nb*DW +: DW] == DW'(tb))
              ie_v = ie_q[ta*NT + tb];
          end
        end
      end
      lk_ie[p*(DW+1) +: DW+1] = {ie_v, 1'b0};
    end
  end

  lattice_energy_adder_tree #(.N(L), .IN_W(DW), .OUT_W(EW)) u_se_tree (
    .terms_i(s1_se_q), .sum_o(se_sum)
  );

  lattice_energy_adder_tree #(.N(L), .IN_W(DW+1), .OUT_W(EW)) u_ie_tree (
    .terms_i(s1_ie_q), .sum_o(ie_sum)
  );

  lattice_energy_adder_tree #(.N(2), .IN_W(EW), .OUT_W(EW)) u_final_tree (
    .terms_i({s2_ie_q, s2_se_q}), .sum_o(total)
  );

  // Lock-step stage advance: a stall holds every stage, bubbles included.
  always_comb begin
    s1_valid_d = s1_valid_q; s1_se_d = s1_se_q; s1_ie_d = s1_ie_q;
    s1_tag_d   = s1_tag_q;   s1_err_d = s1_err_q;
    s2_valid_d = s2_valid_q; s2_se_d = s2_se_q; s2_ie_d = s2_ie_q;
    s2_tag_d   = s2_tag_q;   s2_err_d = s2_err_q;
    out_valid_d = out_valid_q; energy_d = energy_q; tag_d = tag_q; err_d = err_q;
    if (advance) begin
      s1_valid_d = bus.in_valid_i; s1_se_d = lk_se; s1_ie_d = lk_ie;
      s1_tag_d   = bus.ind_tag_i;  s1_err_d = ~&lk_ok;
      s2_valid_d = s1_valid_q; s2_se_d = se_sum; s2_ie_d = ie_sum;
      s2_tag_d   = s1_tag_q;   s2_err_d = s1_err_q;
      out_valid_d = s2_valid_q; energy_d = total; tag_d = s2_tag_q; err_d = s2_err_q;
    end
  end

  // Result counter: clear takes priority over a coincident output handshake.
  always_comb begin
    cnt_d = cnt_q;
    if (pop_clr_i) begin
      cnt_d = '0;
    end else if (out_valid_q & bus.out_ready_i) begin
      cnt_d = (cnt_q == CW'(POP_SIZE - 1)) ? '0 : cnt_q + CW'(1);
    end
  end

  // Configuration and counter state.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned t = 0; t < NT; t++) se_q[t] <= '0;
      for (int unsigned k = 0; k < NT*NT; k++) ie_q[k] <= '0;
      mode_q    <= BND_OPEN;
      cfg_err_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      se_q      <= se_d;
      ie_q      <= ie_d;
      mode_q    <= mode_d;
      cfg_err_q <= cfg_err_d;
      cnt_q     <= cnt_d;
    end
  end

  // Pipeline registers; reset drops any in-flight individual.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0; s1_se_q <= '0; s1_ie_q <= '0; s1_tag_q <= '0; s1_err_q <= 1'b0;
      s2_valid_q <= 1'b0; s2_se_q <= '0; s2_ie_q <= '0; s2_tag_q <= '0; s2_err_q <= 1'b0;
      out_valid_q <= 1'b0; energy_q <= '0; tag_q <= '0; err_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d; s1_se_q <= s1_se_d; s1_ie_q <= s1_ie_d;
      s1_tag_q   <= s1_tag_d;   s1_err_q <= s1_err_d;
      s2_valid_q <= s2_valid_d; s2_se_q <= s2_se_d; s2_ie_q <= s2_ie_d;
      s2_tag_q   <= s2_tag_d;   s2_err_q <= s2_err_d;
      out_valid_q <= out_valid_d; energy_q <= energy_d; tag_q <= tag_d; err_q <= err_d;
    end
  end

endmodule

// File: tb/tb_lattice_energy_pipe.sv
// Directed bench for lattice_energy_pipe with hand-computed expected energies.
module tb_lattice_energy_pipe;

  localparam int unsigned NT = 3;
  localparam int unsigned DW = 4;
  localparam int unsigned L  = 11;
  localparam int unsigned TW = 6;
  localparam int unsigned PS = 50;
  localparam int unsigned EW = 10;

  localparam logic [NT*DW-1:0]    SE_BASIC = 12'h321;
  localparam logic [NT*DW-1:0]    SE_MAX   = 12'hFFF;
  localparam logic [NT*NT*DW-1:0] IE_ONES  = 36'h111111111;
  localparam logic [NT*NT*DW-1:0] IE_MIXED = 36'h987654321;  // IE[a][b] = 3a+b+1
  localparam logic [NT*NT*DW-1:0] IE_MAX   = 36'hFFFFFFFFF;
  localparam logic [L*DW-1:0]     VEC_MIX  = 44'h10210210210; // sites 0..10: 0,1,2,0,1,2,...
  localparam logic [L*DW-1:0]     VEC_BAD4 = 44'h00000030000; // site 4 = code 3

  logic clk_i = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_we_i = 1'b0, periodic_i = 1'b0, pop_clr_i = 1'b0;
  logic [NT*DW-1:0]    self_energy_i = '0;
  logic [NT*NT*DW-1:0] interact_i = '0;
  logic idle_o, cfg_err_o;

  int vecs = 0;
  int errs = 0;

  lattice_energy_pipe_if #(.DATA_WIDTH(DW), .LATTICE_LENGTH(L), .TAG_WIDTH(TW),
                           .ENERGY_WIDTH(EW)) bus ();

  lattice_energy_pipe #(.NUM_TYPES(NT), .DATA_WIDTH(DW), .LATTICE_LENGTH(L),
                        .TAG_WIDTH(TW), .POP_SIZE(PS), .ENERGY_WIDTH(EW)) dut (
    .clk_i(clk_i), .rst_n(rst_n), .cfg_we_i(cfg_we_i), .self_energy_i(self_energy_i),
    .interact_i(interact_i), .periodic_i(periodic_i), .pop_clr_i(pop_clr_i),
    .bus(bus), .idle_o(idle_o), .cfg_err_o(cfg_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [L*DW-1:0] uniform_vec(input logic [DW-1:0] code);
    logic [L*DW-1:0] v;
    for (int i = 0; i < int'(L); i++) v[i*DW +: DW] = code;
    return v;
  endfunction

  task automatic load_cfg(input logic [NT*DW-1:0] se, input logic [NT*NT*DW-1:0] ie,
                          input logic per);
    self_energy_i = se; interact_i = ie; periodic_i = per; cfg_we_i = 1'b1;
    tick();
    cfg_we_i = 1'b0;
  endtask

  // Offers one individual; on return its result is on the outputs.
  task automatic send_one(input logic [L*DW-1:0] v, input logic [TW-1:0] t);
    bus.ind_vec_i = v; bus.ind_tag_i = t; bus.in_valid_i = 1'b1;
    tick();
    bus.in_valid_i = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    vecs++;
    if ({bus.out_valid_o, bus.last_o, bus.type_err_o, cfg_err_o, idle_o, bus.in_ready_o} !== 6'b000011) begin
      errs++; $display("FAIL reset_flags: got %b expected 000011",
        {bus.out_valid_o, bus.last_o, bus.type_err_o, cfg_err_o, idle_o, bus.in_ready_o});
    end
    vecs++;
    if (bus.energy_o !== '0 || bus.tag_o !== '0) begin
      errs++; $display("FAIL reset_data: got energy %0d tag %0d expected 0 0", bus.energy_o, bus.tag_o);
    end
  endtask

  task automatic test_basic();
    load_cfg(SE_BASIC, IE_ONES, 1'b0);
    bus.ind_vec_i = uniform_vec(4'd0); bus.ind_tag_i = 6'd5; bus.in_valid_i = 1'b1;
    tick();
    bus.in_valid_i = 1'b0;
    vecs++;
    if (bus.out_valid_o !== 1'b0) begin errs++; $display("FAIL latency_c1: got %b expected 0", bus.out_valid_o); end
    tick();
    vecs++;
    if (bus.out_valid_o !== 1'b0) begin errs++; $display("FAIL latency_c2: got %b expected 0", bus.out_valid_o); end
    tick();
    vecs++;
    if (bus.out_valid_o !== 1'b1 || bus.energy_o !== 10'd31 || bus.tag_o !== 6'd5 || bus.type_err_o !== 1'b0) begin
      errs++; $display("FAIL basic_open: got v%b e%0d t%0d err%b expected v1 e31 t5 err0",
        bus.out_valid_o, bus.energy_o, bus.tag_o, bus.type_err_o);
    end
    tick();
    vecs++;
    if (bus.out_valid_o !== 1'b0) begin errs++; $display("FAIL basic_drain: got %b expected 0", bus.out_valid_o); end
  endtask

  task automatic test_periodic();
    load_cfg(SE_BASIC, IE_ONES, 1'b1);
    send_one(uniform_vec(4'd0), 6'd6);
    vecs++;
    if (bus.out_valid_o !== 1'b1 || bus.energy_o !== 10'd33) begin
      errs++; $display("FAIL periodic_uniform: got v%b e%0d expected v1 e33", bus.out_valid_o, bus.energy_o);
    end
    tick();
    load_cfg(SE_BASIC, IE_MIXED, 1'b0);
    send_one(VEC_MIX, 6'd7);
    vecs++;
    if (bus.energy_o !== 10'd115 || bus.tag_o !== 6'd7) begin
      errs++; $display("FAIL mixed_open: got e%0d t%0d expected e115 t7", bus.energy_o, bus.tag_o);
    end
    tick();
    load_cfg(SE_BASIC, IE_MIXED, 1'b1);
    send_one(VEC_MIX, 6'd8);
    vecs++;
    if (bus.energy_o !== 10'd123) begin
      errs++; $display("FAIL mixed_periodic: got %0d expected 123", bus.energy_o);
    end
    tick();
  endtask

  task automatic test_worst();
    load_cfg(SE_MAX, IE_MAX, 1'b1);
    send_one(uniform_vec(4'd2), 6'd63);
    vecs++;
    if (bus.energy_o !== 10'd495 || bus.tag_o !== 6'd63 || bus.type_err_o !== 1'b0) begin
      errs++; $display("FAIL worst_case: got e%0d t%0d err%b expected e495 t63 err0",
        bus.energy_o, bus.tag_o, bus.type_err_o);
    end
    tick();
  endtask

  task automatic test_type_err();
    load_cfg(SE_BASIC, IE_ONES, 1'b0);
    send_one(VEC_BAD4, 6'd9);
    vecs++;
    if (bus.energy_o !== 10'd26 || bus.type_err_o !== 1'b1) begin
      errs++; $display("FAIL type_err_bad: got e%0d err%b expected e26 err1", bus.energy_o, bus.type_err_o);
    end
    send_one(uniform_vec(4'd0), 6'd10);
    vecs++;
    if (bus.energy_o !== 10'd31 || bus.type_err_o !== 1'b0) begin
      errs++; $display("FAIL type_err_clean: got e%0d err%b expected e31 err0", bus.energy_o, bus.type_err_o);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int exp3 [3] = '{31, 122, 213};
    int snd = 0, rcv = 0, cyc = 0;
    bit pstall = 1'b0;
    bit extra = 1'b0;
    logic [EW-1:0] pe = '0;
    logic [TW-1:0] pt = '0;
    load_cfg(SE_BASIC, IE_MIXED, 1'b0);
    while (rcv < 8 && cyc < 60) begin
      bus.out_ready_i = !(cyc >= 4 && cyc < 9);
      bus.in_valid_i  = (snd < 8);
      bus.ind_vec_i   = uniform_vec(DW'(snd % 3));
      bus.ind_tag_i   = TW'(10 + snd);
      #1;
      if (pstall) begin
        vecs++;
        if (bus.out_valid_o !== 1'b1 || bus.energy_o !== pe || bus.tag_o !== pt) begin
          errs++; $display("FAIL stall_frozen: got v%b e%0d t%0d expected v1 e%0d t%0d",
            bus.out_valid_o, bus.energy_o, bus.tag_o, pe, pt);
        end
      end
      if (bus.out_valid_o === 1'b1 && bus.out_ready_i === 1'b0) begin
        vecs++;
        if (bus.in_ready_o !== 1'b0) begin
          errs++; $display("FAIL stall_in_ready: got %b expected 0", bus.in_ready_o);
        end
        pstall = 1'b1; pe = bus.energy_o; pt = bus.tag_o;
      end else begin
        pstall = 1'b0;
      end
      if (bus.out_valid_o === 1'b1 && bus.out_ready_i === 1'b1) begin
        vecs++;
        if (bus.energy_o !== EW'(exp3[rcv % 3]) || bus.tag_o !== TW'(10 + rcv)) begin
          errs++; $display("FAIL stream_result_%0d: got e%0d t%0d expected e%0d t%0d",
            rcv, bus.energy_o, bus.tag_o, exp3[rcv % 3], 10 + rcv);
        end
        rcv++;
      end
      if (bus.in_valid_i === 1'b1 && bus.in_ready_o === 1'b1) snd++;
      tick();
      cyc++;
    end
    bus.in_valid_i = 1'b0;
    bus.out_ready_i = 1'b1;
    vecs++;
    if (rcv != 8 || snd != 8) begin
      errs++; $display("FAIL stream_count: got rcv %0d snd %0d expected 8 8", rcv, snd);
    end
    for (int i = 0; i < 4; i++) begin
      if (bus.out_valid_o !== 1'b0) extra = 1'b1;
      tick();
    end
    vecs++;
    if (extra) begin errs++; $display("FAIL stream_duplicate: got extra output expected none"); end
  endtask

  task automatic test_last();
    int snd = 0, rcv = 0, cyc = 0;
    bus.out_ready_i = 1'b1;
    pop_clr_i = 1'b1; tick(); pop_clr_i = 1'b0;
    bus.ind_vec_i = uniform_vec(4'd1);
    while (rcv < 101 && cyc < 200) begin
      bus.in_valid_i = (snd < 101);
      bus.ind_tag_i  = TW'(snd);
      #1;
      if (bus.out_valid_o === 1'b1) begin
        rcv++;
        vecs++;
        if (bus.last_o !== (rcv == 50 || rcv == 100)) begin
          errs++; $display("FAIL last_result_%0d: got %b expected %b", rcv, bus.last_o, (rcv == 50 || rcv == 100));
        end
      end
      if (bus.in_valid_i === 1'b1 && bus.in_ready_o === 1'b1) snd++;
      tick();
      cyc++;
    end
    bus.in_valid_i = 1'b0;
    vecs++;
    if (rcv != 101) begin errs++; $display("FAIL last_count: got %0d expected 101", rcv); end
    tick(); tick(); tick();
    pop_clr_i = 1'b1; tick(); pop_clr_i = 1'b0;
    snd = 0; rcv = 0; cyc = 0;
    while (rcv < 85 && cyc < 200) begin
      bus.in_valid_i = (snd < 85);
      pop_clr_i = (bus.out_valid_o === 1'b1 && rcv + 1 == 30);
      #1;
      if (bus.out_valid_o === 1'b1) begin
        rcv++;
        vecs++;
        if (bus.last_o !== (rcv == 80)) begin
          errs++; $display("FAIL clr_last_result_%0d: got %b expected %b", rcv, bus.last_o, (rcv == 80));
        end
      end
      if (bus.in_valid_i === 1'b1 && bus.in_ready_o === 1'b1) snd++;
      tick();
      cyc++;
    end
    bus.in_valid_i = 1'b0;
    pop_clr_i = 1'b0;
    vecs++;
    if (rcv != 85) begin errs++; $display("FAIL clr_count: got %0d expected 85", rcv); end
    tick(); tick(); tick();
  endtask

  task automatic test_cfg_busy();
    load_cfg(SE_BASIC, IE_MIXED, 1'b0);
    bus.ind_vec_i = uniform_vec(4'd1); bus.ind_tag_i = 6'd21; bus.in_valid_i = 1'b1;
    tick();
    bus.in_valid_i = 1'b0;
    self_energy_i = SE_MAX; interact_i = IE_MAX; periodic_i = 1'b1; cfg_we_i = 1'b1;
    tick();
    cfg_we_i = 1'b0;
    vecs++;
    if (cfg_err_o !== 1'b1) begin errs++; $display("FAIL cfg_busy_err: got %b expected 1", cfg_err_o); end
    tick();
    vecs++;
    if (cfg_err_o !== 1'b0) begin errs++; $display("FAIL cfg_err_pulse: got %b expected 0", cfg_err_o); end
    vecs++;
    if (bus.out_valid_o !== 1'b1 || bus.energy_o !== 10'd122 || bus.tag_o !== 6'd21) begin
      errs++; $display("FAIL cfg_busy_result: got v%b e%0d t%0d expected v1 e122 t21",
        bus.out_valid_o, bus.energy_o, bus.tag_o);
    end
    tick();
    bus.ind_vec_i = uniform_vec(4'd2); bus.ind_tag_i = 6'd22; bus.in_valid_i = 1'b1; cfg_we_i = 1'b1;
    tick();
    bus.in_valid_i = 1'b0; cfg_we_i = 1'b0;
    vecs++;
    if (cfg_err_o !== 1'b1) begin errs++; $display("FAIL cfg_inval_err: got %b expected 1", cfg_err_o); end
    tick(); tick();
    vecs++;
    if (bus.out_valid_o !== 1'b1 || bus.energy_o !== 10'd213) begin
      errs++; $display("FAIL cfg_inval_result: got v%b e%0d expected v1 e213", bus.out_valid_o, bus.energy_o);
    end
    tick();
    load_cfg(SE_MAX, IE_MAX, 1'b1);
    vecs++;
    if (cfg_err_o !== 1'b0) begin errs++; $display("FAIL cfg_accept_err: got %b expected 0", cfg_err_o); end
    send_one(uniform_vec(4'd1), 6'd23);
    vecs++;
    if (bus.energy_o !== 10'd495) begin
      errs++; $display("FAIL cfg_new_table: got %0d expected 495", bus.energy_o);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bit leak = 1'b0;
    bus.out_ready_i = 1'b0;
    bus.ind_vec_i = uniform_vec(4'd0); bus.in_valid_i = 1'b1;
    for (int i = 0; i < 10 && bus.out_valid_o !== 1'b1; i++) tick();
    vecs++;
    if (bus.out_valid_o !== 1'b1) begin errs++; $display("FAIL rst_fill: got %b expected 1", bus.out_valid_o); end
    #2 rst_n = 1'b0;
    #1;
    vecs++;
    if (bus.out_valid_o !== 1'b0 || idle_o !== 1'b1) begin
      errs++; $display("FAIL rst_async: got v%b idle%b expected v0 idle1", bus.out_valid_o, idle_o);
    end
    bus.in_valid_i = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.out_valid_o !== 1'b0) leak = 1'b1;
    end
    vecs++;
    if (leak) begin errs++; $display("FAIL rst_partial: got output after reset expected none"); end
  endtask

  initial begin
    bus.in_valid_i = 1'b0;
    bus.ind_vec_i = '0;
    bus.ind_tag_i = '0;
    bus.out_ready_i = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_basic();
    test_periodic();
    test_worst();
    test_type_err();
    test_back_to_back();
    test_last();
    test_cfg_busy();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
